// File: rtl/inst_memory.sv
// inst_memory
//   Read-only instruction memory holding a fixed built-in RV32I program.
//   Returns the little-endian 32-bit word starting at any byte address,
//   registered on the rising clock edge. Bytes at or beyond DEPTH_BYTES
//   read as zero; there is no aliasing or wrap-around.
//
// Ports
//   clk      : system clock, rising-edge active
//   rst      : asynchronous active-high reset, clears inst_out
//   PC_out   : byte address of the instruction to fetch
//   inst_out : registered instruction word
module inst_memory #(
  parameter int unsigned DEPTH_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_out,
  output logic [31:0] inst_out
);

  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [32:0] DEPTH_33 = 33'(DEPTH_BYTES);

  function automatic logic [31:0] init_word(input int unsigned widx);
    case (widx)
      0:       return 32'h0050_0093; // addi x1,x0,5
      1:       return 32'h00A0_0113; // addi x2,x0,10
      2:       return 32'h0020_81B3; // add  x3,x1,x2
      3:       return 32'h4011_0233; // sub  x4,x2,x1
      4:       return 32'h0020_F2B3; // and  x5,x1,x2
      5:       return 32'h0020_E333; // or   x6,x1,x2
      default: return 32'h0000_0013; // nop
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input int unsigned baddr);
    logic [31:0] w;
    w = init_word(baddr / 4);
    return w[8*(baddr % 4) +: 8];
  endfunction

  // Constant byte array; each entry is tied off at elaboration.
  logic [7:0] mem [DEPTH_BYTES];

  for (genvar gi = 0; gi < int'(DEPTH_BYTES); gi++) begin : g_mem
    assign mem[gi] = init_byte(gi);
  end

  logic [31:0] inst_d;
  logic [31:0] inst_q;

  // Byte addresses are formed at 33 bits so PC_out near 2^32 cannot wrap
  // back into the valid range.
  always_comb begin
    logic [32:0] baddr;
    inst_d = '0;
    for (int k = 0; k < 4; k++) begin
      baddr = {1'b0, PC_out} + 33'(k);
      if (baddr < DEPTH_33) begin
        inst_d[8*k +: 8] = mem[baddr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q <= '0;
    end else begin
      inst_q <= inst_d;
    end
  end

  assign inst_out = inst_q;

endmodule

// File: tb/tb_inst_memory.sv
module tb_inst_memory;

  logic        clk;
  logic        rst;
  logic [31:0] PC_out;
  logic [31:0] inst_out;

  int n_checks;
  int n_fail;

  inst_memory #(.DEPTH_BYTES(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .PC_out   (PC_out),
    .inst_out (inst_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the program as a word list, fill with nop, zero past the end.
  logic [31:0] prog [6];
  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h4011_0233;
    prog[4] = 32'h0020_F2B3;
    prog[5] = 32'h0020_E333;
  end

  function automatic logic [7:0] ref_byte(input longint addr);
    logic [31:0] w;
    if (addr >= 256) return 8'h00;
    w = (addr / 4 < 6) ? prog[addr / 4] : 32'h0000_0013;
    return 8'((w >> (8 * (addr % 4))) & 32'hFF);
  endfunction

  function automatic logic [31:0] ref_fetch(input logic [31:0] pc);
    longint a;
    a = longint'(pc);
    return {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply an address before the edge, then sample just after it.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input string tag);
    @(negedge clk);
    PC_out = pc;
    @(posedge clk);
    #1;
    check(tag, inst_out, exp);
  endtask

  initial begin
    logic [31:0] pc;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    PC_out   = 32'h0;

    #1;
    check("reset_async", inst_out, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", inst_out, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", inst_out, 32'h0050_0093);

    fetch(32'd4,  32'h00A0_0113, "seq4");
    fetch(32'd8,  32'h0020_81B3, "seq8");
    fetch(32'd12, 32'h4011_0233, "seq12");
    fetch(32'd16, 32'h0020_F2B3, "seq16");
    fetch(32'd20, 32'h0020_E333, "seq20");
    fetch(32'd2,  32'h0113_0050, "misal2");
    fetch(32'd1,  ref_fetch(32'd1), "misal1");
    fetch(32'd24, 32'h0000_0013, "fill24");
    fetch(32'd252, 32'h0000_0013, "fill252");
    fetch(32'd254, 32'h0000_0000, "top254");
    fetch(32'd253, 32'h0000_0000, "top253");
    fetch(32'd255, 32'h0000_0000, "top255");
    fetch(32'h0000_1000, 32'h0000_0000, "oor1000");
    fetch(32'hFFFF_FFFF, 32'h0000_0000, "oor_wrap");
    fetch(32'h0000_0100, 32'h0000_0000, "oor256");

    // Async reset mid-run
    fetch(32'd8, 32'h0020_81B3, "pre_rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_async", inst_out, 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_hold", inst_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_reload", inst_out, 32'h0020_81B3);

    // Hold between edges
    fetch(32'd0, 32'h0050_0093, "hold_pre");
    @(negedge clk);
    PC_out = 32'd8;
    #2;
    check("hold_between", inst_out, 32'h0050_0093);
    @(posedge clk);
    #1;
    check("hold_after", inst_out, 32'h0020_81B3);

    // Randomized fetches, weighted toward the populated region and the top edge
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: pc = $urandom_range(0, 31);
        1: pc = $urandom_range(240, 270);
        2: pc = $urandom_range(0, 255);
        default: pc = $urandom;
      endcase
      fetch(pc, ref_fetch(pc), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
